// File: rtl/mux_n_1_reg.sv
// Registered N:1 multiplexer with valid/ready on both sides.
// Channel choice is either explicit (sel) or round-robin over valid inputs;
// the chosen beat lands in a single-entry output register.
module mux_n_1_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_ch
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic             load_en;
  logic [SEL_W-1:0] grant;
  logic             grant_v;
  logic [SEL_W-1:0] rr_hi, rr_lo;
  logic             rr_hi_found, rr_lo_found;
  logic [WIDTH-1:0] grant_data;

  assign load_en = !out_valid_q || out_ready;

  // Round-robin search: lowest valid channel above last wins, else lowest at or below last.
  always_comb begin
    rr_hi       = '0;
    rr_lo       = '0;
    rr_hi_found = 1'b0;
    rr_lo_found = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        if (SEL_W'(i) > last_q) begin
          rr_hi       = SEL_W'(i);
          rr_hi_found = 1'b1;
        end else begin
          rr_lo       = SEL_W'(i);
          rr_lo_found = 1'b1;
        end
      end
    end
  end

  // Grant selection; explicit select compares against each channel so sel >= N grants nothing.
  always_comb begin
    grant   = '0;
    grant_v = 1'b0;
    if (mode) begin
      grant   = rr_hi_found ? rr_hi : rr_lo;
      grant_v = rr_hi_found || rr_lo_found;
    end else begin
      grant = sel;
      for (int i = 0; i < int'(N); i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_v = 1'b1;
        end
      end
    end
  end

  // Per-channel ready and data pick; ready is forced low while reset is held.
  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant == SEL_W'(i)) begin
        in_ready[i] = rst && load_en && grant_v;
        grant_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state for the output register and round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    last_d      = last_q;
    if (load_en) begin
      if (grant_v) begin
        out_valid_d = 1'b1;
        out_data_d  = grant_data;
        out_ch_d    = grant;
        last_d      = grant;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State register; reset points last at N-1 so channel 0 is served first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      last_q      <= SEL_W'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_n_1_reg.sv
// Self-checking bench for mux_n_1_reg (WIDTH=8, N=4, SEL_W=2).
module tb_mux_n_1_reg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N     = 4;
  localparam int unsigned SEL_W = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   out_ch;

  int errors = 0;
  int checks = 0;

  mux_n_1_reg #(
    .WIDTH(WIDTH),
    .N    (N),
    .SEL_W(SEL_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .sel      (sel),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic        ordy;
    logic [31:0] data;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [7:0]  exp_od;
    logic [1:0]  exp_och;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r,
                     input logic [31:0] d, input logic [3:0] er, input logic eov,
                     input logic [7:0] eod, input logic [1:0] eoc);
    vec_t t;
    t.mode = m; t.sel = s; t.vld = v; t.ordy = r; t.data = d;
    t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_och = eoc;
    vecs.push_back(t);
  endtask

  // Reference model state
  int          m_ov, m_last, m_och;
  logic [7:0]  m_od;

  initial begin
    logic [31:0] rr_d;
    logic [31:0] ex_d;
    bit          load, gv;
    int          g;
    logic [3:0]  exp_rdy;

    rr_d = 32'h13121110;
    ex_d = 32'h13A51110;

    // Directed sequence starting from reset (last=3, out_valid=0)
    add(1, 0, 4'b1111, 1, rr_d, 4'b0001, 1, 8'h10, 0);  // first rr grant is ch0
    add(0, 2, 4'b0100, 1, ex_d, 4'b0100, 1, 8'hA5, 2);  // explicit select
    add(0, 1, 4'b0100, 1, ex_d, 4'b0000, 0, 8'hA5, 2);  // sel on idle channel -> bubble
    add(0, 3, 4'b1000, 1, rr_d, 4'b1000, 1, 8'h13, 3);  // set last=3
    add(1, 0, 4'b1111, 1, rr_d, 4'b0001, 1, 8'h10, 0);  // rr wrap 0,1,2,3,0,1
    add(1, 0, 4'b1111, 1, rr_d, 4'b0010, 1, 8'h11, 1);
    add(1, 0, 4'b1111, 1, rr_d, 4'b0100, 1, 8'h12, 2);
    add(1, 0, 4'b1111, 1, rr_d, 4'b1000, 1, 8'h13, 3);
    add(1, 0, 4'b1111, 1, rr_d, 4'b0001, 1, 8'h10, 0);
    add(1, 0, 4'b1111, 1, rr_d, 4'b0010, 1, 8'h11, 1);
    add(1, 0, 4'b1000, 1, rr_d, 4'b1000, 1, 8'h13, 3);  // grant ch3
    add(1, 0, 4'b1010, 1, rr_d, 4'b0010, 1, 8'h11, 1);  // sparse 1,3,1,3
    add(1, 0, 4'b1010, 1, rr_d, 4'b1000, 1, 8'h13, 3);
    add(1, 0, 4'b1010, 1, rr_d, 4'b0010, 1, 8'h11, 1);
    add(1, 0, 4'b1010, 1, rr_d, 4'b1000, 1, 8'h13, 3);
    add(0, 1, 4'b1111, 1, rr_d, 4'b0010, 1, 8'h11, 1);  // load 8'h11, last=1
    add(1, 0, 4'b1111, 0, rr_d, 4'b0000, 1, 8'h11, 1);  // backpressure x3
    add(1, 0, 4'b1111, 0, rr_d, 4'b0000, 1, 8'h11, 1);
    add(1, 0, 4'b1111, 0, rr_d, 4'b0000, 1, 8'h11, 1);
    add(1, 0, 4'b1111, 1, rr_d, 4'b0100, 1, 8'h12, 2);  // drain + load same edge
    add(1, 0, 4'b0000, 1, rr_d, 4'b0000, 0, 8'h12, 2);  // nothing valid: drop valid, hold data
    add(1, 0, 4'b0001, 0, rr_d, 4'b0001, 1, 8'h10, 0);  // empty register loads despite !out_ready

    // Reset phase
    rst = 1'b0; mode = 1'b1; sel = '0; out_ready = 1'b1;
    in_valid = 4'b1111; in_data = rr_d;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'h00);
    check("reset_out_ch", 32'(out_ch), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'h0);
    in_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven directed vectors
    foreach (vecs[i]) begin
      mode = vecs[i].mode; sel = vecs[i].sel; in_valid = vecs[i].vld;
      out_ready = vecs[i].ordy; in_data = vecs[i].data;
      #1;
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_od));
      check($sformatf("vec%0d_out_ch", i), 32'(out_ch), 32'(vecs[i].exp_och));
    end

    // Asynchronous reset while a beat is held
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_data", 32'(out_data), 32'h00);
    check("async_rst_in_ready", 32'(in_ready), 32'h0);
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; in_data = rr_d;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'b0001);
    @(posedge clk);
    #1;
    check("post_rst_out_ch", 32'(out_ch), 32'd0);
    check("post_rst_out_data", 32'(out_data), 32'h10);
    m_ov = 1; m_od = 8'h10; m_och = 0; m_last = 0;

    // Randomized stimulus against the behavioural model
    for (int it = 0; it < 400; it++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;

      load = (m_ov == 0) || out_ready;
      g    = 0;
      gv   = 0;
      if (mode == 1'b0) begin
        g  = int'(sel);
        gv = in_valid[g];
      end else begin
        for (int k = 1; k <= int'(N); k++) begin
          int c;
          c = (m_last + k) % int'(N);
          if (!gv && in_valid[c]) begin
            g  = c;
            gv = 1;
          end
        end
      end
      exp_rdy = (load && gv) ? 4'(1 << g) : 4'b0000;

      #1;
      check("rand_in_ready", 32'(in_ready), 32'(exp_rdy));
      @(posedge clk);
      #1;
      if (load) begin
        if (gv) begin
          m_ov   = 1;
          m_od   = in_data[g*8 +: 8];
          m_och  = g;
          m_last = g;
        end else begin
          m_ov = 0;
        end
      end
      check("rand_out_valid", 32'(out_valid), 32'(m_ov));
      check("rand_out_data", 32'(out_data), 32'(m_od));
      check("rand_out_ch", 32'(out_ch), 32'(m_och));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_n_1_reg.md
Name: mux_n_1_reg

Overview:
- Parametrised, registered N:1 multiplexer. It is the clocked successor to the datapath 2:1 select muxes.
- Selects one of N input channels, either explicitly via sel or by round-robin among valid channels.
- Passes the chosen beat through a single-entry output register with valid/ready handshakes on both sides.
- Used in the KGP-RISC datapath wherever several producers (ALU, memory, immediate/PC paths) share one registered consumer port.

Parameters:
- WIDTH, 32, data width per channel in bits.
- N, 4, number of input channels; must be ≥ 2.
- SEL_W, 2, width of sel and out_ch; must satisfy 2^SEL_W ≥ N.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- mode  input  1  0 = explicit select via sel; 1 = round-robin among valid inputs.
- sel  input  SEL_W  channel index, used only when mode=0.
- in_data  input  N*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; one-hot or zero.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data holds a beat.
- out_ready  input  1  downstream accepts beat.
- out_ch  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, out_data=0, out_ch=0, and the round-robin pointer last=N-1, so ch0 has first priority. All in_ready are 0 while rst=0.
- Load enable: load_en = !out_valid | out_ready. This is combinational, giving full throughput of one beat per cycle when out_ready is held high.
- Grant, mode=0: grant=sel and grant_v=in_valid[sel]. If sel ≥ N, grant_v=0 (no channel granted, no X propagation).
- Grant, mode=1: scan channels (last+1) mod N, (last+2) mod N, … up to last, with wrap-around. grant is the first valid channel found; grant_v=|in_valid.
- in_ready[i] = load_en & grant_v & (grant==i). This is combinational; at most one bit is high.
- Transfer on input i occurs when in_valid[i] & in_ready[i]. On the next edge: out_data<=channel i data, out_ch<=i, out_valid<=1, last<=i. The last pointer updates in both modes.
- load_en=1 with grant_v=0: on the next edge out_valid<=0. out_data and out_ch hold their previous values, and last is unchanged.
- load_en=0 (out_valid=1 & out_ready=0): output is stalled. out_data, out_ch and out_valid hold, and all in_ready are 0.
- Latency: 1 cycle from input handshake to out_valid.
- Simultaneous drain and load: when out_valid=1, out_ready=1 and grant_v=1, the old beat is consumed and the new beat is loaded on the same edge, with no bubble.
- Changing mode or sel mid-stream takes effect at the next grant evaluation. A beat already held in the output register is unaffected.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0 and every channel is served once per N beats.
- Reset asserted mid-operation: any held beat is discarded and out_valid drops immediately (asynchronous). The pointer returns to N-1.
- Output stability: out_data must not change while out_valid=1 and out_ready=0.

Test Plan (WIDTH=8, N=4, SEL_W=2):
- Reset: hold rst=0 with in_valid=4'b1111 → out_valid=0, out_data=8'h00, in_ready=4'b0000. Release rst; with mode=1 and out_ready=1 → first grant is ch0, in_ready=4'b0001.
- Explicit select: mode=0, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1 → next cycle out_data=8'hA5, out_ch=2, out_valid=1. Change sel=1 with in_valid[1]=0 → next cycle out_valid=0.
- Round-robin wrap: mode=1, in_valid=4'b1111, data ch i = 8'h10+i, out_ready=1 for 6 cycles → out_ch sequence 0,1,2,3,0,1 and out_data 8'h10,11,12,13,10,11, with no bubbles.
- Sparse round-robin: mode=1, in_valid=4'b1010 after a grant to ch3 → next grants are 1,3,1,3.
- Backpressure: out_valid=1, out_data=8'h11, out_ready=0 for 3 cycles while in_valid=4'b1111 → out_data stays 8'h11, in_ready=4'b0000. On out_ready=1 → the next channel loads on the same edge the old beat drains.
- Reset mid-stream: assert rst=0 between edges while out_valid=1 → out_valid=0 immediately, without waiting for a clock edge. After release, the first round-robin grant is ch0.
